// File: rtl/modmul_sched_pkg.sv
// Shared types for the modular-multiplier scheduler.
// State encoding, pipeline tag and id-width helper.
package modmul_sched_pkg;

    typedef enum logic [1:0] {
        S_NOQ,
        S_RUN,
        S_DRAIN,
        S_LOAD
    } state_e;

    localparam int MAX_IDW = 4;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/modmul_rr_arb.sv
// NREQ-wide arbiter: round-robin from ptr_i, or fixed priority
// when MODMUL_SCHED_PRIO_EN is defined (lowest index wins).
module modmul_rr_arb
    import modmul_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    assign any_o = |req_i;

`ifdef MODMUL_SCHED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin : sel
        logic found;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IDW'(k);
            end
        end
    end
`else
    always_comb begin : sel
        logic found;
        int   cand;
        found = 1'b0;
        cand  = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDW'(cand);
            end
        end
    end
`endif

endmodule

// File: rtl/modmul_sched.sv
// Shares one pipelined modmul between NREQ requesters and owns q.
// Define MODMUL_SCHED_PRIO_EN for fixed-priority arbitration.
module modmul_sched
    import modmul_sched_pkg::*;
#(
    parameter  int LOGQ   = 32,
    parameter  int NREQ   = 4,
    parameter  int MM_LAT = 8,
    localparam int IDW    = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*LOGQ-1:0] req_a,
    input  logic [NREQ*LOGQ-1:0] req_b,
    input  logic              cfg_valid,
    input  logic [LOGQ-1:0]   cfg_q,
    output logic              cfg_ready,
    output logic [LOGQ-1:0]   mm_q,
    output logic [LOGQ-1:0]   mm_a,
    output logic [LOGQ-1:0]   mm_b,
    input  logic [LOGQ-1:0]   mm_c,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [LOGQ-1:0]   rsp_c,
    output logic              busy
);

    state_e          state_q, state_d;
    logic [LOGQ-1:0] q_q, q_d;
    logic [LOGQ-1:0] a_q, b_q;
    logic [IDW-1:0]  ptr_q, ptr_d;
    tag_t            tag_q [MM_LAT+1];
    tag_t            tag0_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx;
    logic            any_req;
    logic            issue;
    logic            busy_w;

    modmul_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (idx),
        .any_o (any_req)
    );

    // cfg_valid blocks issue in RUN so draining starts immediately
    assign issue = (state_q == S_RUN) && !cfg_valid && any_req;
    assign req_ready = issue ? gnt : '0;

    always_comb begin
        busy_w = 1'b0;
        for (int k = 0; k <= MM_LAT; k++) begin
            busy_w = busy_w | tag_q[k].valid;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        cfg_ready = 1'b0;
        unique case (state_q)
            S_NOQ: begin
                if (cfg_valid) state_d = S_LOAD;
            end
            S_RUN: begin
                if (cfg_valid) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!busy_w) state_d = S_LOAD;
            end
            S_LOAD: begin
                q_d       = cfg_q;
                cfg_ready = 1'b1;
                state_d   = S_RUN;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
        tag0_d              = '0;
        tag0_d.valid        = issue;
        tag0_d.id[IDW-1:0]  = idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_NOQ;
            q_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ptr_q   <= '0;
            for (int k = 0; k <= MM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            ptr_q    <= ptr_d;
            tag_q[0] <= tag0_d;
            for (int k = 1; k <= MM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            if (issue) begin
                a_q <= req_a[idx*LOGQ +: LOGQ];
                b_q <= req_b[idx*LOGQ +: LOGQ];
            end
        end
    end

    logic unused_tag_id;
    assign unused_tag_id = ^tag_q[MM_LAT].id;

    assign mm_q      = q_q;
    assign mm_a      = a_q;
    assign mm_b      = b_q;
    assign rsp_valid = tag_q[MM_LAT].valid;
    assign rsp_id    = tag_q[MM_LAT].id[IDW-1:0];
    assign rsp_c     = mm_c;
    assign busy      = busy_w;

endmodule

// File: tb/tb_modmul_sched.sv
// Directed bench for modmul_sched with a modmul model and scoreboard.
module tb_modmul_sched;

    localparam int LOGQ   = 32;
    localparam int NREQ   = 4;
    localparam int MM_LAT = 8;
    localparam int IDW    = 2;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*LOGQ-1:0] req_a;
    logic [NREQ*LOGQ-1:0] req_b;
    logic                 cfg_valid;
    logic [LOGQ-1:0]      cfg_q;
    logic                 cfg_ready;
    logic [LOGQ-1:0]      mm_q;
    logic [LOGQ-1:0]      mm_a;
    logic [LOGQ-1:0]      mm_b;
    logic [LOGQ-1:0]      mm_c;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [LOGQ-1:0]      rsp_c;
    logic                 busy;

    modmul_sched #(
        .LOGQ   (LOGQ),
        .NREQ   (NREQ),
        .MM_LAT (MM_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .cfg_valid (cfg_valid),
        .cfg_q     (cfg_q),
        .cfg_ready (cfg_ready),
        .mm_q      (mm_q),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_c      (mm_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .busy      (busy)
    );

    typedef struct {
        int          id;
        logic [31:0] c;
        int          cyc;
    } exp_t;

    int          vectors;
    int          miscompares;
    int          cyc;
    logic [31:0] cur_q;
    exp_t        sb[$];
    int          gq[$];
    int          rq[$];
    logic [31:0] pipe [MM_LAT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mmod(input logic [31:0] a, b, q);
        if (q == 0) return 32'd0;
        return 32'((64'(a) * 64'(b)) % 64'(q));
    endfunction

    // Reference modmul: MM_LAT registers from mm_a/mm_b to mm_c
    always @(posedge clk) begin
        pipe[0] <= mmod(mm_a, mm_b, mm_q);
        for (int k = 1; k < MM_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mm_c = pipe[MM_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, b);
        req_a[i*LOGQ +: LOGQ] = a;
        req_b[i*LOGQ +: LOGQ] = b;
    endtask

    // Handshake capture just before each rising edge
    initial forever begin
        @(negedge clk);
        #3;
        if (!rst) begin
            chk("gnt_legal",
                {62'd0, $onehot0(req_ready), |(req_ready & ~req_valid)},
                64'd2);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gq.push_back(i);
                    sb.push_back('{id: i,
                        c: mmod(req_a[i*LOGQ +: LOGQ],
                                req_b[i*LOGQ +: LOGQ], cur_q),
                        cyc: cyc});
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rsp_valid) begin
            rq.push_back(int'(rsp_id));
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_c", rsp_c, e.c);
                chk("rsp_lat", cyc - e.cyc, MM_LAT + 1);
            end
        end
    end

    task automatic do_cfg(input logic [31:0] q, output int lat,
                          output int sbn, output int gqn);
        bit got;
        cfg_q = q;
        cfg_valid = 1'b1;
        lat = 0;
        got = 0;
        sbn = -1;
        gqn = -1;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            #1;
            if (cfg_ready) begin
                got = 1;
                cur_q = q;
                sbn = sb.size();
                gqn = gq.size();
            end
        end
        if (!got) chk("cfg_timeout", 0, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic issue1(input int i, input logic [31:0] a, b,
                          output int k);
        req_valid = '0;
        req_valid[i] = 1'b1;
        set_op(i, a, b);
        #1;
        chk("issue_ready", req_ready, 64'(1) << i);
        @(negedge clk);
        req_valid = '0;
        k = 1;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int lat, sbn, gqn, k;
        vectors = 0;
        miscompares = 0;
        cyc = 0;
        cur_q = 0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        cfg_valid = 1'b0;
        cfg_q = '0;
        for (int i = 0; i < MM_LAT; i++) pipe[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mm_q", mm_q, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_b", mm_b, 0);
        chk("rst_rsp_id", rsp_id, 0);
        rst = 1'b0;

        // No modulus loaded: requests are ignored
        @(negedge clk);
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'(i + 5));
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("noq_ready", req_ready, 0);
        end
        @(negedge clk);
        do_cfg(32'd97, lat, sbn, gqn);
        chk("cfg_lat", lat, 1);
        #1;
        chk("first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        drain();

        // Single op: 50*3 mod 97
        issue1(0, 32'd50, 32'd3, k);
        chk("t2_lat", k, MM_LAT + 1);
        chk("t2_id", rsp_id, 0);
        chk("t2_c", rsp_c, 53);
        drain();

        // Leaves the round-robin pointer at 0
        issue1(3, 32'd7, 32'd11, k);
        chk("t3_pre_c", rsp_c, 77);
        drain();

        // All requesters for 8 cycles
        gq.delete();
        rq.delete();
        req_valid = '1;
        for (int i = 0; i < NREQ; i++)
            set_op(i, 32'(1000 * i + 3), 32'(i + 90));
        repeat (8) @(negedge clk);
        req_valid = '0;
        drain();
        chk("t3_ngnt", gq.size(), 8);
        chk("t3_nrsp", rq.size(), 8);
        for (int j = 0; j < 8 && j < gq.size() && j < rq.size(); j++) begin
`ifdef MODMUL_SCHED_PRIO_EN
            chk("t3_gnt", gq[j], 0);
            chk("t3_rsp", rq[j], 0);
`else
            chk("t3_gnt", gq[j], j % 4);
            chk("t3_rsp", rq[j], j % 4);
`endif
        end

        // Modulus change while streaming
        req_valid = '1;
        repeat (5) @(negedge clk);
        gq.delete();
        cfg_q = 32'd65537;
        cfg_valid = 1'b1;
        #1;
        chk("t4_gate", req_ready, 0);
        do_cfg(32'd65537, lat, sbn, gqn);
        chk("t4_drain_lat", lat, MM_LAT + 2);
        chk("t4_old_done", sbn, 0);
        chk("t4_no_gnt", gqn, 0);
        issue1(0, 32'd70000, 32'd70000, k);
        chk("t4_mm_q", mm_q, 65537);
        chk("t4_c", rsp_c, 60658);
        drain();

        // req0 and req2 contending
        gq.delete();
        req_valid = 4'b0101;
        repeat (6) @(negedge clk);
        req_valid = '0;
        drain();
        chk("t5_ngnt", gq.size(), 6);
        for (int j = 0; j < gq.size(); j++) begin
`ifdef MODMUL_SCHED_PRIO_EN
            chk("t5_gnt", gq[j], 0);
`else
            chk("t5_gnt", gq[j], (j % 2 == 0) ? 2 : 0);
`endif
        end

        // Reset with five operations in flight
        req_valid = 4'b0001;
        set_op(0, 32'd12, 32'd34);
        repeat (5) @(negedge clk);
        req_valid = '0;
        #1;
        chk("t6_busy_pre", busy, 1);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_valid = '1;
        repeat (20) begin
            @(negedge clk);
            #1;
            chk("t6_rsp_valid", rsp_valid, 0);
            chk("t6_busy", busy, 0);
            chk("t6_ready", req_ready, 0);
        end
        @(negedge clk);
        do_cfg(32'd97, lat, sbn, gqn);
        issue1(1, 32'd96, 32'd96, k);
        chk("t6_new_id", rsp_id, 1);
        chk("t6_new_c", rsp_c, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
